// File: rtl/ud_count_ctrl.sv
// Up/down step counter controller: accepts a direction and step-count command, steps count once per cycle.
// Boundary behaviour set by macro UD_SAT_EN (undefined: wrap modulo 32; defined: saturate and end the command).
module ud_count_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [4:0] cmd_steps,
    input  logic       abort,
    input  logic       cnt_clr,
    output logic [4:0] count,
    output logic       up_down,
    output logic       busy,
    output logic       done,
    output logic       wrap
);

`ifdef UD_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_count;
    logic [4:0] r_remaining;
    logic       r_up_down;
    logic       r_wrap;

    logic       w_accept;
    logic       w_clear;
    logic       w_step;
    logic       w_at_bound;
    logic       w_last;
    logic       w_sat_hit;
    logic [4:0] w_count_step;

    // cnt_clr wins over a simultaneous command in IDLE
    assign w_clear    = (r_state == S_IDLE) && cnt_clr;
    assign w_accept   = (r_state == S_IDLE) && cmd_valid && !cnt_clr;
    assign w_step     = (r_state == S_RUN) && !abort;
    assign w_at_bound = r_up_down ? (r_count == 5'd31) : (r_count == 5'd0);
    assign w_last     = (r_remaining == 5'd1);
    assign w_sat_hit  = SAT_EN && w_at_bound;

    always_comb begin
        w_count_step = r_count;
        if (!w_sat_hit) begin
            w_count_step = r_up_down ? (r_count + 5'd1) : (r_count - 5'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (cmd_steps == 5'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_sat_hit || w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE:  cmd_ready = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE:  done      = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // wrap marks the cycle after a step attempted past either end of the range
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= 5'd0;
            r_up_down   <= 1'b0;
            r_remaining <= 5'd0;
            r_wrap      <= 1'b0;
        end else begin
            r_wrap <= w_step && w_at_bound;
            if (w_clear) begin
                r_count <= 5'd0;
            end else if (w_step) begin
                r_count <= w_count_step;
            end
            if (w_accept) begin
                r_up_down   <= cmd_dir;
                r_remaining <= cmd_steps;
            end else if (w_step) begin
                r_remaining <= w_sat_hit ? 5'd0 : (r_remaining - 5'd1);
            end
        end
    end

    assign count   = r_count;
    assign up_down = r_up_down;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_ud_count_ctrl.sv
// Scoreboard bench for ud_count_ctrl: stimulus queues cycle-tagged expected outputs, a negedge monitor checks them.
module tb_ud_count_ctrl;

`ifdef UD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [4:0] cmd_steps;
    logic       abort;
    logic       cnt_clr;
    logic [4:0] count;
    logic       up_down;
    logic       busy;
    logic       done;
    logic       wrap;

    ud_count_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .cnt_clr   (cnt_clr),
        .count     (count),
        .up_down   (up_down),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int         cyc;
        logic [9:0] vec;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [9:0] obs;
    assign obs = {cmd_ready, busy, done, wrap, up_down, count};

    function automatic logic [9:0] mk(input logic r, input logic b, input logic dn,
                                      input logic w, input logic ud, input logic [4:0] c);
        return {r, b, dn, w, ud, c};
    endfunction

    function automatic void check_vec(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got rdy=%b busy=%b done=%b wrap=%b ud=%b cnt=%0d, required rdy=%b busy=%b done=%b wrap=%b ud=%b cnt=%0d",
                     name, got[9], got[8], got[7], got[6], got[5], got[4:0],
                     exp[9], exp[8], exp[7], exp[6], exp[5], exp[4:0]);
        end
    endfunction

    // Monitor: compare every expectation whose cycle has arrived
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            e = sb_q.pop_front();
            check_vec(e.name, obs, e.vec);
        end
    end

    // Drive one cycle of inputs; expected outputs after the coming edge are queued
    task automatic cyc(input logic v, input logic d, input logic [4:0] s, input logic a,
                       input logic c, input logic [9:0] e, input string nm);
        cmd_valid = v;
        cmd_dir   = d;
        cmd_steps = s;
        abort     = a;
        cnt_clr   = c;
        sb_q.push_back('{cyc_cnt + 1, e, nm});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [9:0] e, input string nm);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, e, nm);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = 5'd0;
        abort     = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("txn: reset held");
        check_vec("reset_hold", obs, mk(1, 0, 0, 0, 0, 5'd0));
        reset = 1'b0;
        idle(mk(1, 0, 0, 0, 0, 5'd0), "after_reset");

        $display("txn: up 5 from 0");
        cyc(1, 1, 5'd5, 0, 0, mk(0, 1, 0, 0, 1, 5'd0), "up5_accept");
        for (int i = 1; i <= 4; i++) idle(mk(0, 1, 0, 0, 1, 5'(i)), "up5_step");
        idle(mk(0, 0, 1, 0, 1, 5'd5), "up5_done");
        idle(mk(1, 0, 0, 0, 1, 5'd5), "up5_idle");

        $display("txn: zero-step down");
        cyc(1, 0, 5'd0, 0, 0, mk(0, 0, 1, 0, 0, 5'd5), "zero_done");
        idle(mk(1, 0, 0, 0, 0, 5'd5), "zero_idle");

        $display("txn: up 4 from 5");
        cyc(1, 1, 5'd4, 0, 0, mk(0, 1, 0, 0, 1, 5'd5), "up4_accept");
        for (int i = 6; i <= 8; i++) idle(mk(0, 1, 0, 0, 1, 5'(i)), "up4_step");
        idle(mk(0, 0, 1, 0, 1, 5'd9), "up4_done");
        idle(mk(1, 0, 0, 0, 1, 5'd9), "up4_idle");

        $display("txn: clear with simultaneous command at 9");
        cyc(1, 0, 5'd3, 0, 1, mk(1, 0, 0, 0, 1, 5'd0), "clr_vs_cmd");
        idle(mk(1, 0, 0, 0, 1, 5'd0), "clr_not_accepted");

        $display("txn: up 3 from 0");
        cyc(1, 1, 5'd3, 0, 0, mk(0, 1, 0, 0, 1, 5'd0), "up3_accept");
        for (int i = 1; i <= 2; i++) idle(mk(0, 1, 0, 0, 1, 5'(i)), "up3_step");
        idle(mk(0, 0, 1, 0, 1, 5'd3), "up3_done");
        idle(mk(1, 0, 0, 0, 1, 5'd3), "up3_idle");

        $display("txn: down 6 from 3");
        cyc(1, 0, 5'd6, 0, 0, mk(0, 1, 0, 0, 0, 5'd3), "down6_accept");
        for (int i = 2; i >= 0; i--) idle(mk(0, 1, 0, 0, 0, 5'(i)), "down6_step");
        if (SAT) begin
            idle(mk(0, 0, 1, 1, 0, 5'd0), "down6_sat_done");
            idle(mk(1, 0, 0, 0, 0, 5'd0), "down6_sat_idle");
        end else begin
            idle(mk(0, 1, 0, 1, 0, 5'd31), "down6_wrap");
            idle(mk(0, 1, 0, 0, 0, 5'd30), "down6_step30");
            idle(mk(0, 0, 1, 0, 0, 5'd29), "down6_done");
            idle(mk(1, 0, 0, 0, 0, 5'd29), "down6_idle");
        end

        $display("txn: single steps across the boundary");
        cyc(0, 0, 5'd0, 0, 1, mk(1, 0, 0, 0, 0, 5'd0), "clr_idle");
        cyc(1, 0, 5'd1, 0, 0, mk(0, 1, 0, 0, 0, 5'd0), "down1_accept");
        idle(mk(0, 0, 1, 1, 0, SAT ? 5'd0 : 5'd31), "down1_bound");
        idle(mk(1, 0, 0, 0, 0, SAT ? 5'd0 : 5'd31), "down1_idle");
        cyc(1, 1, 5'd1, 0, 0, mk(0, 1, 0, 0, 1, SAT ? 5'd0 : 5'd31), "up1_accept");
        idle(mk(0, 0, 1, !SAT, 1, SAT ? 5'd1 : 5'd0), "up1_bound");
        idle(mk(1, 0, 0, 0, 1, SAT ? 5'd1 : 5'd0), "up1_idle");

        $display("txn: up 10 aborted on 4th run cycle");
        cyc(0, 0, 5'd0, 0, 1, mk(1, 0, 0, 0, 1, 5'd0), "clr_before_abort");
        cyc(1, 1, 5'd10, 0, 0, mk(0, 1, 0, 0, 1, 5'd0), "up10_accept");
        for (int i = 1; i <= 3; i++) idle(mk(0, 1, 0, 0, 1, 5'(i)), "up10_step");
        cyc(0, 0, 5'd0, 1, 0, mk(1, 0, 0, 0, 1, 5'd3), "abort_run");
        idle(mk(1, 0, 0, 0, 1, 5'd3), "abort_no_done");

        $display("txn: up 10 then reset mid-run at 7");
        cyc(1, 1, 5'd10, 1, 0, mk(0, 1, 0, 0, 1, 5'd3), "abort_ignored_idle");
        for (int i = 4; i <= 7; i++) idle(mk(0, 1, 0, 0, 1, 5'(i)), "pre_reset_step");
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_vec("reset_immediate", obs, mk(1, 0, 0, 0, 0, 5'd0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) idle(mk(1, 0, 0, 0, 0, 5'd0), "post_reset");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ud_count_ctrl.md
UD_COUNT_CTRL -- requirements
Module: ud_count_ctrl

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset, with ports clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 cmd_valid  input  1  a command is offered.
REQ-005 cmd_ready  output  1  the block accepts a command; high only in IDLE.
REQ-006 cmd_dir  input  1  command direction: 1=up, 0=down; sampled at accept.
REQ-007 cmd_steps  input  5  number of unit steps, 0..31; sampled at accept.
REQ-008 abort  input  1  terminates a running command.
REQ-009 cnt_clr  input  1  synchronous clear of count; honoured only in IDLE.
REQ-010 count  output  5  counter value, registered.
REQ-011 up_down  output  1  latched direction of the current or last command, registered.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  one-cycle pulse on command completion.
REQ-014 wrap  output  1  one-cycle pulse on a boundary event.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE, with DONE lasting exactly one cycle and always followed by IDLE.
REQ-016 In IDLE, cmd_valid=1 SHALL accept the command at that edge, latch cmd_dir into up_down and latch cmd_steps into a 5-bit remaining counter.
REQ-017 A command accepted with cmd_steps=0 SHALL go directly to DONE, and count SHALL NOT change.
REQ-018 A command accepted with cmd_steps=N>0 at edge k SHALL go to RUN, change count by one per edge at edges k+1..k+N, and enter DONE at edge k+N.
REQ-019 done SHALL be high exactly while in DONE, i.e. for the cycle after the last step.
REQ-020 In RUN, cmd_valid SHALL be ignored and cmd_ready SHALL be 0.
REQ-021 In RUN, abort=1 at an edge SHALL suppress that edge's step, hold count and return to IDLE without a done pulse; abort SHALL be ignored outside RUN.
REQ-022 In IDLE, cnt_clr=1 SHALL set count to 0 at that edge; cnt_clr SHALL take priority over a simultaneous cmd_valid, which is not accepted that cycle.
REQ-023 Count arithmetic SHALL be 5-bit unsigned.
REQ-024 wrap SHALL pulse in the cycle following any step attempted from 31 upward or from 0 downward.

Reset
REQ-025 Assertion of reset SHALL immediately force state=IDLE, count=0, up_down=0, remaining=0, busy=0, done=0 and wrap=0, including in the middle of a command.
REQ-026 cmd_ready SHALL be 1 while reset is asserted and after it is released.
REQ-027 Any command in flight SHALL be discarded on reset and SHALL NOT complete after reset is released.

Configuration
REQ-028 The macro UD_SAT_EN SHALL select the boundary behaviour.
REQ-029 With UD_SAT_EN undefined, a step at a boundary SHALL wrap modulo 32 (31 to 0 up, 0 to 31 down), pulse wrap, and the command SHALL continue.
REQ-030 With UD_SAT_EN defined, a step at a boundary SHALL hold count, pulse wrap, discard the remaining steps and enter DONE at that edge.

Verification
REQ-031 Reset, then cmd up with steps=5 -> count 1,2,3,4,5 on successive edges, done pulses once, cmd_ready returns to 1.
REQ-032 count=3, cmd down with steps=6 -> without UD_SAT_EN: count 2,1,0,31,30,29, one wrap pulse; with UD_SAT_EN: count 2,1,0, then held at 0, wrap and done pulse.
REQ-033 cmd up with steps=10, abort asserted on the 4th RUN cycle -> count stops at 3, no done pulse, IDLE.
REQ-034 cmd with steps=0 -> no count change, done pulses on the cycle after accept.
REQ-035 Reset asserted mid-RUN at count=7 -> count=0 immediately, IDLE, no done pulse after release.
REQ-036 In IDLE at count=9, cnt_clr and cmd_valid asserted together -> count=0, command not accepted, cmd_ready still 1.
